// File: rtl/mem_responder.sv
// Memory-side endpoint: in-order request queue feeding a fixed-latency pipeline
// over an internal word array. One response per accepted request.
module mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int BW          = 8,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 4,
  parameter int QDEPTH      = 8,
  parameter int ID_W        = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic                                   req_we,
  input  logic [ID_W-1:0]                        req_id,
  input  logic [ADDR_W-1:0]                      req_addr,
  input  logic [BW*8-1:0]                        req_wdata,
  input  logic                                   mem_stall,
  output logic                                   rsp_valid,
  output logic [BW*8-1:0]                        rsp_data,
  output logic [ID_W-1:0]                        rsp_id,
  output logic                                   rsp_we,
  output logic                                   busy,
  output logic [$clog2(QDEPTH+LATENCY+1)-1:0]    outstanding
);
  localparam int DW  = BW * 8;
  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int QAW = $clog2(QDEPTH);
  localparam int OW  = $clog2(QDEPTH + LATENCY + 1);

  typedef struct packed {
    logic            we;
    logic [ID_W-1:0] id;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
  } req_t;

  req_t           q_mem [QDEPTH];
  req_t           new_req, head;
  logic [QAW-1:0] wr_ptr_q, rd_ptr_q;
  logic [QAW:0]   cnt_q;
  logic [OW-1:0]  out_q;
  logic           full, push, pop;

  logic [DW-1:0]  mem_q [DEPTH_WORDS];

  logic [LATENCY:1] vld_pipe;
  logic [DW-1:0]    dat_pipe [1:LATENCY];
  logic [ID_W-1:0]  id_pipe  [1:LATENCY];
  logic             we_pipe  [1:LATENCY];

  // Only the low address bits index the array; the rest wrap.
  generate
    if (ADDR_W > AW) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[ADDR_W-1:AW];
    end
  endgenerate

  assign new_req   = '{we: req_we, id: req_id, addr: req_addr[AW-1:0], wdata: req_wdata};
  assign head      = q_mem[rd_ptr_q];
  assign full      = (cnt_q == (QAW+1)'(QDEPTH));
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (cnt_q != '0) && !mem_stall;

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q] <= new_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (QAW+1)'(push) - (QAW+1)'(pop);
      out_q <= out_q + OW'(push) - OW'(rsp_valid);
    end
  end

  // Array is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (pop && head.we) mem_q[head.addr] <= head.wdata;
  end

  // Stage 1 samples the array at pop, so a read after a same-address write
  // one cycle earlier sees the committed data. Data stages hold on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 1; i <= LATENCY; i++) begin
        dat_pipe[i] <= '0;
        id_pipe[i]  <= '0;
        we_pipe[i]  <= 1'b0;
      end
    end else begin
      vld_pipe[1] <= pop;
      if (pop) begin
        dat_pipe[1] <= head.we ? '0 : mem_q[head.addr];
        id_pipe[1]  <= head.id;
        we_pipe[1]  <= head.we;
      end
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) begin
          dat_pipe[i] <= dat_pipe[i-1];
          id_pipe[i]  <= id_pipe[i-1];
          we_pipe[i]  <= we_pipe[i-1];
        end
      end
    end
  end

  assign rsp_valid   = vld_pipe[LATENCY];
  assign rsp_data    = dat_pipe[LATENCY];
  assign rsp_id      = id_pipe[LATENCY];
  assign rsp_we      = we_pipe[LATENCY];
  assign busy        = (cnt_q != '0) || (|vld_pipe);
  assign outstanding = out_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table plus hand-written sequences
// for latency, stall/full, reset and a scoreboarded stream.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [1:0]  req_id = '0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        mem_stall = 1'b0;
  logic        rsp_valid, rsp_we, busy;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_id;
  logic [3:0]  outstanding;

  mem_responder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_id(req_id), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_stall(mem_stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_we(rsp_we), .busy(busy), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic [1:0] id; logic we; int cyc; } rsp_t;
  typedef struct {
    logic we; logic [1:0] id; logic [15:0] addr; logic [63:0] wdata;
    logic [63:0] exp_data;
  } vec_t;

  rsp_t got[$];
  rsp_t expq[$];
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n && rsp_valid) got.push_back('{rsp_data, rsp_id, rsp_we, cyc});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(logic we, logic [1:0] id, logic [15:0] a, logic [63:0] d);
    req_valid = 1'b1; req_we = we; req_id = id; req_addr = a; req_wdata = d;
  endtask

  task automatic send(logic we, logic [1:0] id, logic [15:0] a, logic [63:0] d);
    drive(we, id, a, d);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(int n, int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin tick(); k++; end
    if (got.size() < n) chk("rsp_timeout", 64'(got.size()), 64'(n));
  endtask

  task automatic drain();
    int k = 0;
    while (busy && k < 100) begin tick(); k++; end
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  vec_t vecs[8];
  localparam logic [63:0] PAT = 64'hA5A5_A5A5_A5A5_A5A5;

  initial begin
    int acc, r;
    logic [63:0] m [16];

    // Reset state
    #12;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_we", 64'(rsp_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single read latency
    send(1'b1, 2'd0, 16'h0010, PAT);
    wait_rsp(1, 20);
    drain();
    got.delete();
    drive(1'b0, 2'd0, 16'h0010, 64'd0);
    chk("t1_out_c0", 64'(outstanding), 64'd0);
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("t1_valid_c%0d", c), 64'(rsp_valid), 64'(c == 5));
      chk($sformatf("t1_out_c%0d", c), 64'(outstanding), (c <= 5) ? 64'd1 : 64'd0);
      if (c == 5) begin
        chk("t1_data", rsp_data, PAT);
        chk("t1_id", 64'(rsp_id), 64'd0);
        chk("t1_we", 64'(rsp_we), 64'd0);
      end
      tick();
    end
    chk("t1_hold_data", rsp_data, PAT);

    // Vector table: write/read back-to-back, wrap, repeat write
    vecs[0] = '{1'b1, 2'd1, 16'h0020, 64'h1234, 64'd0};
    vecs[1] = '{1'b0, 2'd2, 16'h0020, 64'd0,    64'h1234};
    vecs[2] = '{1'b1, 2'd0, 16'h1003, 64'h55,   64'd0};
    vecs[3] = '{1'b0, 2'd1, 16'h0003, 64'd0,    64'h55};
    vecs[4] = '{1'b0, 2'd2, 16'h0010, 64'd0,    PAT};
    vecs[5] = '{1'b1, 2'd2, 16'h0020, 64'hBEEF, 64'd0};
    vecs[6] = '{1'b0, 2'd0, 16'hF020, 64'd0,    64'hBEEF};
    vecs[7] = '{1'b0, 2'd1, 16'h1010, 64'd0,    PAT};
    got.delete();
    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].id, vecs[i].addr, vecs[i].wdata);
      tick();
    end
    req_valid = 1'b0;
    wait_rsp(8, 40);
    foreach (vecs[i]) if (i < got.size()) begin
      chk($sformatf("vec%0d_data", i), got[i].data, vecs[i].exp_data);
      chk($sformatf("vec%0d_id", i), 64'(got[i].id), 64'(vecs[i].id));
      chk($sformatf("vec%0d_we", i), 64'(got[i].we), 64'(vecs[i].we));
      if (i > 0) chk($sformatf("vec%0d_cyc", i), 64'(got[i].cyc), 64'(got[0].cyc + i));
    end
    drain();

    // Stall and full
    got.delete();
    mem_stall = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'(i % 3), 16'(16'h0100 + i), 64'(16'h1000 + i));
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    chk("t3_accepted", 64'(acc), 64'd8);
    chk("t3_ready_full", 64'(req_ready), 64'd0);
    chk("t3_outstanding", 64'(outstanding), 64'd8);
    chk("t3_no_rsp_stalled", 64'(got.size()), 64'd0);
    r = cyc;
    mem_stall = 1'b0;
    wait_rsp(8, 40);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      chk($sformatf("t3_id%0d", i), 64'(got[i].id), 64'(i % 3));
      chk($sformatf("t3_cyc%0d", i), 64'(got[i].cyc), 64'(r + 4 + i));
    end
    drain();
    chk("t3_out_end", 64'(outstanding), 64'd0);
    chk("t3_extra_rsp", 64'(got.size()), 64'd8);

    // Reset mid-flight
    send(1'b1, 2'd0, 16'h0030, 64'h77);
    drain();
    got.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'(i), 16'h0030, 64'd0);
      tick();
    end
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_out", 64'(outstanding), 64'd0);
    chk("t5_ready", 64'(req_ready), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_valid", 64'(rsp_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t5_no_rsp", 64'(got.size()), 64'd0);
    send(1'b0, 2'd2, 16'h0030, 64'd0);
    wait_rsp(1, 20);
    if (got.size() > 0) chk("t5_keep_data", got[0].data, 64'h77);
    drain();

    // Sustained random stream against a model
    got.delete();
    expq.delete();
    for (int i = 0; i < 64; i++) begin
      logic        we;
      logic [3:0]  a, hi;
      logic [63:0] d;
      logic [1:0]  id;
      we = (i < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      a  = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
      hi = 4'($urandom_range(0, 15));
      d  = {$urandom, $urandom};
      id = 2'($urandom_range(0, 2));
      if (!req_ready) chk("t6_ready", 64'(req_ready), 64'd1);
      drive(we, id, {hi, 12'h200 | 12'(a)}, d);
      if (we) m[a] = d;
      expq.push_back('{we ? 64'd0 : m[a], id, we, 0});
      tick();
    end
    req_valid = 1'b0;
    wait_rsp(64, 100);
    for (int i = 0; i < 64 && i < got.size(); i++) begin
      chk($sformatf("t6_data%0d", i), got[i].data, expq[i].data);
      chk($sformatf("t6_id%0d", i), 64'(got[i].id), 64'(expq[i].id));
      chk($sformatf("t6_we%0d", i), 64'(got[i].we), 64'(expq[i].we));
      if (i > 0) chk($sformatf("t6_cyc%0d", i), 64'(got[i].cyc), 64'(got[0].cyc + i));
    end
    drain();
    chk("t6_out_end", 64'(outstanding), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
